// File: rtl/int_to_float_encoder.sv
// int_to_float_encoder: signed/unsigned IN_W-bit integer to IEEE-754 single.
// Normalizes one left shift per cycle, then rounds to nearest-even.
// Optional out_type one-hot class output enabled by FLOAT_ENC_TYPE_EN.
module int_to_float_encoder #(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_int,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_float,
  output logic            out_inexact
`ifdef FLOAT_ENC_TYPE_EN
  ,
  output logic [4:0]      out_type
`endif
);

  localparam int E0 = 127 + IN_W - 1;
  // Mantissa body below the hidden bit, widened so guard and sticky always exist.
  localparam int XW = ((IN_W - 1) > 25) ? (IN_W - 1) : 25;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [7:0]        exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [31:0]       float_q, float_d;
  logic              inexact_q, inexact_d;
  logic [4:0]        type_q, type_d;

  logic [XW-1:0]     body;
  logic [22:0]       frac_t, frac_r;
  logic              guard, sticky, rnd_up;
  logic [23:0]       frac_sum;
  logic [7:0]        exp_r;

  // Round-to-nearest-even on the normalized magnitude.
  always_comb begin
    body = '0;
    body[XW-1 -: (IN_W-1)] = mag_q[IN_W-2:0];
    frac_t   = body[XW-1 -: 23];
    guard    = body[XW-24];
    sticky   = |body[XW-25:0];
    rnd_up   = guard & (sticky | frac_t[0]);
    frac_sum = {1'b0, frac_t} + {23'd0, rnd_up};
    if (frac_sum[23]) begin
      frac_r = '0;
      exp_r  = exp_q + 8'd1;
    end else begin
      frac_r = frac_sum[22:0];
      exp_r  = exp_q;
    end
  end

  // Next-state and datapath update for the conversion FSM.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    float_d   = float_q;
    inexact_d = inexact_q;
    type_d    = type_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_signed & in_int[IN_W-1];
          mag_d  = (in_signed & in_int[IN_W-1]) ? -in_int : in_int;
          exp_d  = 8'(E0);
          if (in_int == '0) begin
            float_d   = '0;
            inexact_d = 1'b0;
            type_d    = 5'b00001;
            state_d   = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mag_q[IN_W-1]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      S_ROUND: begin
        float_d   = {sign_q, exp_r, frac_r};
        inexact_d = guard | sticky;
        type_d    = 5'b00010;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      float_q   <= '0;
      inexact_q <= 1'b0;
      type_q    <= '0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      float_q   <= float_d;
      inexact_q <= inexact_d;
      type_q    <= type_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_float   = float_q;
  assign out_inexact = inexact_q;

`ifdef FLOAT_ENC_TYPE_EN
  assign out_type = type_q;
`else
  logic unused_type;
  assign unused_type = ^type_q;
`endif

endmodule

// File: tb/tb_int_to_float_encoder.sv
// Self-checking bench for int_to_float_encoder (IN_W = 32): directed spec
// vectors plus random operands checked against an arithmetic reference model.
module tb_int_to_float_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_int = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_float;
  logic        out_inexact;
`ifdef FLOAT_ENC_TYPE_EN
  logic [4:0]  out_type;
`endif

  int n_total = 0;
  int n_bad   = 0;

  int_to_float_encoder #(.IN_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_int      (in_int),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_float   (out_float),
    .out_inexact (out_inexact)
`ifdef FLOAT_ENC_TYPE_EN
    ,
    .out_type    (out_type)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: value-level conversion with explicit nearest-even rounding.
  task automatic ref_conv(input logic [31:0] v, input logic s,
                          output logic [31:0] f, output logic inx, output int lat);
    logic [63:0] m, q, rem, half;
    int p, e, sh;
    m = (s && v[31]) ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    f = '0; inx = 1'b0; lat = 0;
    if (m != 0) begin
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      e = 127 + p;
      if (p <= 23) begin
        q = m << (23 - p);
      end else begin
        sh   = p - 23;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e = e + 1;
        end
      end
      f   = {s & v[31], e[7:0], q[22:0]};
      lat = (31 - p) + 2;
    end
  endtask

  // One transaction: hold=1 stalls the result 5 cycles with out_ready low
  // while a competing operand is offered; hold=0 keeps out_ready high.
  task automatic run_one(input logic [31:0] v, input logic s, input logic hold,
                         input logic [31:0] ef, input logic ei, input int el);
    int lat;
    logic [31:0] f0;
    @(negedge clk);
    check_eq("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_int = v; in_signed = s; in_valid = 1'b1; out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0; in_int = $urandom; in_signed = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 64'(lat), 64'(el));
    check_eq("float", {32'd0, out_float}, {32'd0, ef});
    check_eq("inexact", {63'd0, out_inexact}, {63'd0, ei});
`ifdef FLOAT_ENC_TYPE_EN
    check_eq("type", {59'd0, out_type}, (ef == 32'd0) ? 64'd1 : 64'd2);
`endif
    if (hold) begin
      f0 = out_float;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        in_valid = 1'b1; in_int = $urandom | 32'd1; in_signed = 1'b0;
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_float", {32'd0, out_float}, {32'd0, f0});
        check_eq("hold_busy", {63'd0, in_ready}, 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("drain_valid", {63'd0, out_valid}, 64'd0);
    check_eq("drain_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] v;
    logic        s;
    logic [31:0] f;
    logic        inx;
  } vec_t;

  initial begin
    vec_t dir[$];
    logic [31:0] rf, rv;
    logic        ri, rs;
    int          rl;

    dir.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0});
    dir.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0});
    dir.push_back('{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0});
    dir.push_back('{32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0});
    dir.push_back('{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1});
    dir.push_back('{32'd16777217,  1'b0, 32'h4B80_0000, 1'b1});
    dir.push_back('{32'd16777219,  1'b0, 32'h4B80_0002, 1'b1});
    dir.push_back('{32'd7,         1'b0, 32'h40E0_0000, 1'b0});
    dir.push_back('{32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0});

    // Reset state.
    #12;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_float", {32'd0, out_float}, 64'd0);
    check_eq("rst_inexact", {63'd0, out_inexact}, 64'd0);
`ifdef FLOAT_ENC_TYPE_EN
    check_eq("rst_type", {59'd0, out_type}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (dir[i]) begin
      ref_conv(dir[i].v, dir[i].s, rf, ri, rl);
      run_one(dir[i].v, dir[i].s, (i == 6) || (i == 1), dir[i].f, dir[i].inx, rl);
    end

    // Reset asserted while normalizing aborts the conversion.
    @(negedge clk);
    in_int = 32'd1; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", {63'd0, out_valid}, 64'd0);
    check_eq("abort_ready", {63'd0, in_ready}, 64'd1);
    check_eq("abort_float", {32'd0, out_float}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check_eq("abort_no_result", 64'(seen), 64'd0);
    end
    out_ready = 1'b0;

    // Random operands with varied magnitudes.
    for (int n = 0; n < 40; n++) begin
      rv = $urandom;
      rv = rv >> $urandom_range(0, 31);
      rs = $urandom_range(0, 1);
      if (rs && $urandom_range(0, 1) == 1) rv = -rv;
      ref_conv(rv, rs, rf, ri, rl);
      run_one(rv, rs, ($urandom_range(0, 7) == 0), rf, ri, rl);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
